// File: rtl/boot_loader_pkg.sv
// Shared types and widths for the instruction-memory boot loader.
package boot_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CHECK,
    ST_DONE,
    ST_ERROR
  } state_e;

  typedef struct packed {
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } imem_wr_t;

endpackage

// File: rtl/byte_packer.sv
// Four-byte big-endian shift register; first byte shifted in ends up in the top byte.
module byte_packer
  import boot_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift,
  input  logic [BYTE_W-1:0] shift_data,
  output logic [WORD_W-1:0] word,
  output logic [1:0]        count,
  output logic              word_full
);

  // word_full marks that the most recent shift completed a 4-byte word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word      <= '0;
      count     <= '0;
      word_full <= 1'b0;
    end else if (clear) begin
      word      <= '0;
      count     <= '0;
      word_full <= 1'b0;
    end else if (shift) begin
      word      <= {word[WORD_W-BYTE_W-1:0], shift_data};
      count     <= count + 2'd1;
      word_full <= (count == 2'd3);
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads a framed byte stream into instruction memory and holds the core until
// a complete frame with a matching XOR checksum has been written.
module imem_boot_loader
  import boot_loader_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_inc;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [BYTE_W-1:0]  acc_q, acc_d;
  logic               pk_clear, pk_shift, pk_full;
  logic [WORD_W-1:0]  pk_word;
  logic [1:0]         pk_count;
  logic               accept, len_bad;
  imem_wr_t           wr_q, wr_d;
  logic               we_d, done_d, error_d, hold_d;

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (reset),
    .clear      (pk_clear),
    .shift      (pk_shift),
    .shift_data (in_data),
    .word       (pk_word),
    .count      (pk_count),
    .word_full  (pk_full)
  );

  assign in_ready = !((state_q == ST_WRITE) || (state_q == ST_DONE));
  assign accept   = in_valid && in_ready;
  assign len_bad  = (in_data == 8'h00) || (32'(in_data) > 32'(IMEM_DEPTH));
  assign idx_inc  = idx_q + IDX_W'(1);

  // next-state, datapath updates and registered-output inputs
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    acc_d    = acc_q;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    we_d     = 1'b0;
    wr_d     = wr_q;

    unique case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (accept && (in_data == SYNC_BYTE)) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (accept) begin
          if (len_bad) begin
            state_d = ST_ERROR;
          end else begin
            len_d    = IDX_W'(in_data);
            idx_d    = '0;
            acc_d    = '0;
            pk_clear = 1'b1;
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          pk_shift = 1'b1;
          acc_d    = acc_q ^ in_data;
          if (pk_count == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        we_d    = pk_full;
        wr_d    = '{addr: BASE_ADDR + (32'(idx_q) << 2), data: pk_word};
        idx_d   = idx_inc;
        state_d = (idx_inc == len_q) ? ST_CHECK : ST_DATA;
      end
      ST_CHECK: begin
        if (accept) state_d = (in_data == acc_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase

    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
    hold_d  = !done_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      acc_q     <= '0;
      wr_q      <= '{addr: BASE_ADDR, data: '0};
      imem_we   <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      acc_q     <= acc_d;
      wr_q      <= wr_d;
      imem_we   <= we_d;
      done      <= done_d;
      error     <= error_d;
      core_hold <= hold_d;
    end
  end

  assign imem_addr  = wr_q.addr;
  assign imem_wdata = wr_q.data;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: two instances (base 0 and base 0x100) share one
// byte stream; a frame-parsing model predicts writes, done and error.
module tb_imem_boot_loader;

  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready0, we0, hold0, done0, error0;
  logic        in_ready1, we1, hold1, done1, error1;
  logic [31:0] addr0, wdata0, addr1, wdata1;

  imem_boot_loader #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE0), .SYNC_BYTE(8'hA5)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
    .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0), .core_hold(hold0),
    .done(done0), .error(error0));

  imem_boot_loader #(.IMEM_DEPTH(DEPTH), .BASE_ADDR(BASE1), .SYNC_BYTE(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1), .core_hold(hold1),
    .done(done1), .error(error1));

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stl = 0;
  logic [63:0] got0[$];
  logic [63:0] got1[$];
  logic [7:0]  stim[$];
  logic [31:0] exp_data[$];
  int          exp_idx[$];
  bit          exp_done, exp_error;

  // capture every write strobe as {addr, data}
  always @(negedge clk) begin
    if (we0) got0.push_back({addr0, wdata0});
    if (we1) got1.push_back({addr1, wdata1});
  end

  // frame parser over the whole byte stream fed since reset
  task automatic model_run();
    int pos = 0;
    int n = stim.size();
    int len;
    logic [7:0]  chk;
    logic [31:0] w;
    exp_data.delete(); exp_idx.delete();
    exp_done = 1'b0; exp_error = 1'b0;
    while (pos < n && !exp_done) begin
      if (stim[pos] != 8'hA5) begin pos++; continue; end
      pos++;
      exp_error = 1'b0;
      if (pos >= n) break;
      len = int'(stim[pos]);
      pos++;
      if (len == 0 || len > int'(DEPTH)) begin exp_error = 1'b1; continue; end
      chk = 8'h00;
      for (int i = 0; i < len; i++) begin
        if (pos + 4 > n) begin pos = n; break; end
        w = {stim[pos], stim[pos+1], stim[pos+2], stim[pos+3]};
        chk = chk ^ stim[pos] ^ stim[pos+1] ^ stim[pos+2] ^ stim[pos+3];
        exp_data.push_back(w);
        exp_idx.push_back(i);
        pos += 4;
      end
      if (pos >= n) break;
      if (stim[pos] == chk) exp_done = 1'b1;
      else exp_error = 1'b1;
      pos++;
    end
  endtask

  function automatic logic [63:0] exp_wr(input logic [31:0] base, input int i);
    return {base + 32'(exp_idx[i]) * 32'd4, exp_data[i]};
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int waited = 0;
    if (gaps && $urandom_range(3) == 0) begin
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      repeat ($urandom_range(2, 1)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready0 && waited < 20) begin
      @(negedge clk);
      waited++; stl++; cyc++;
    end
    total++;
    if (!in_ready0) begin
      bad++;
      $display("FAIL send_timeout byte=%02h in_ready=%0b required=1", b, in_ready0);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_bytes(input logic [7:0] bytes[$], input bit gaps);
    cyc = 0; stl = 0;
    foreach (bytes[i]) begin
      send_byte(bytes[i], gaps);
      stim.push_back(bytes[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got0.delete(); got1.delete(); stim.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if (we0 !== 1'b0 || addr0 !== BASE0 || wdata0 !== 32'h0 || hold0 !== 1'b1 ||
        done0 !== 1'b0 || error0 !== 1'b0 || in_ready0 !== 1'b1 || addr1 !== BASE1) begin
      bad++;
      $display("FAIL reset_values we=%0b addr=%h/%h wdata=%h hold=%0b done=%0b err=%0b rdy=%0b required 0 %h/%h 0 1 0 0 1",
               we0, addr0, addr1, wdata0, hold0, done0, error0, in_ready0, BASE0, BASE1);
    end
  endtask

  task automatic test_single_word();
    apply_reset();
    send_bytes('{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (got0.size() != 1 || got1.size() != 1) begin
      bad++;
      $display("FAIL single_count got=%0d/%0d required=1", got0.size(), got1.size());
    end else begin
      total++;
      if (got0[0] !== 64'h0000_0000_DEAD_BEEF || got1[0] !== 64'h0000_0100_DEAD_BEEF) begin
        bad++;
        $display("FAIL single_write got=%h/%h required=%h/%h", got0[0], got1[0],
                 64'h0000_0000_DEAD_BEEF, 64'h0000_0100_DEAD_BEEF);
      end
    end
    total++;
    if (done0 !== 1'b1 || hold0 !== 1'b0 || done1 !== 1'b1 || error0 !== 1'b0) begin
      bad++;
      $display("FAIL single_done done=%0b hold=%0b err=%0b required 1 0 0", done0, hold0, error0);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    send_bytes('{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h03}, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (cyc != 13 || stl != 2) begin
      bad++;
      $display("FAIL b2b_timing cycles=%0d stalls=%0d required 13 2", cyc, stl);
    end
    model_run();
    total++;
    if (got0.size() != exp_data.size() || got1.size() != exp_data.size()) begin
      bad++;
      $display("FAIL b2b_count got=%0d/%0d required=%0d", got0.size(), got1.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        total++;
        if (got0[i] !== exp_wr(BASE0, i) || got1[i] !== exp_wr(BASE1, i)) begin
          bad++;
          $display("FAIL b2b_write%0d got=%h/%h required=%h/%h", i, got0[i], got1[i],
                   exp_wr(BASE0, i), exp_wr(BASE1, i));
        end
      end
    end
    total++;
    if (done0 !== exp_done || done1 !== exp_done || hold0 !== !exp_done) begin
      bad++;
      $display("FAIL b2b_done done=%0b hold=%0b required done=%0b", done0, hold0, exp_done);
    end
  endtask

  task automatic test_bad_retry();
    apply_reset();
    send_bytes('{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h00}, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (error0 !== 1'b1 || hold0 !== 1'b1 || done0 !== 1'b0 || error1 !== 1'b1) begin
      bad++;
      $display("FAIL badchk_state err=%0b hold=%0b done=%0b required 1 1 0", error0, hold0, done0);
    end
    send_bytes('{8'hA5}, 1'b0);
    total++;
    if (error0 !== 1'b0 || error1 !== 1'b0) begin
      bad++;
      $display("FAIL retry_err_clear err=%0b/%0b required 0", error0, error1);
    end
    send_bytes('{8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44}, 1'b1);
    repeat (2) @(negedge clk);
    model_run();
    total++;
    if (got0.size() != exp_data.size() || got1.size() != exp_data.size()) begin
      bad++;
      $display("FAIL retry_count got=%0d/%0d required=%0d", got0.size(), got1.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        total++;
        if (got0[i] !== exp_wr(BASE0, i) || got1[i] !== exp_wr(BASE1, i)) begin
          bad++;
          $display("FAIL retry_write%0d got=%h/%h required=%h/%h", i, got0[i], got1[i],
                   exp_wr(BASE0, i), exp_wr(BASE1, i));
        end
      end
    end
    total++;
    if (done0 !== exp_done || error0 !== exp_error || hold0 !== !exp_done || done0 !== 1'b1) begin
      bad++;
      $display("FAIL retry_done done=%0b err=%0b hold=%0b required 1 0 0", done0, error0, hold0);
    end
  endtask

  task automatic test_len_limits();
    logic [7:0] fr[$];
    logic [7:0] b, chk;
    // zero length and one past capacity are both rejected without writes
    for (int k = 0; k < 2; k++) begin
      apply_reset();
      send_bytes('{8'h00, 8'hFF, 8'h3C, 8'hA5, (k == 0) ? 8'h00 : 8'h41}, 1'b0);
      repeat (2) @(negedge clk);
      total++;
      if (error0 !== 1'b1 || error1 !== 1'b1 || done0 !== 1'b0 || hold0 !== 1'b1 || got0.size() != 0) begin
        bad++;
        $display("FAIL len_reject%0d err=%0b done=%0b hold=%0b writes=%0d required 1 0 1 0",
                 k, error0, done0, hold0, got0.size());
      end
    end
    // full-capacity frame behind leading noise
    apply_reset();
    fr = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h40};
    chk = 8'h00;
    for (int i = 0; i < 4 * int'(DEPTH); i++) begin
      b = 8'($urandom);
      chk ^= b;
      fr.push_back(b);
    end
    fr.push_back(chk);
    send_bytes(fr, 1'b0);
    repeat (2) @(negedge clk);
    model_run();
    total++;
    if (got0.size() != exp_data.size() || got1.size() != exp_data.size() || exp_data.size() != 64) begin
      bad++;
      $display("FAIL fullcap_count got=%0d/%0d required=%0d", got0.size(), got1.size(), exp_data.size());
    end else begin
      foreach (exp_data[i]) begin
        total++;
        if (got0[i] !== exp_wr(BASE0, i) || got1[i] !== exp_wr(BASE1, i)) begin
          bad++;
          $display("FAIL fullcap_write%0d got=%h/%h required=%h/%h", i, got0[i], got1[i],
                   exp_wr(BASE0, i), exp_wr(BASE1, i));
        end
      end
    end
    total++;
    if (done0 !== exp_done || done1 !== exp_done || error0 !== exp_error) begin
      bad++;
      $display("FAIL fullcap_done done=%0b err=%0b required %0b %0b", done0, error0, exp_done, exp_error);
    end
  endtask

  task automatic test_reset_midframe();
    apply_reset();
    send_bytes('{8'hA5, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h11, 8'h22}, 1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if (we0 !== 1'b0 || addr0 !== BASE0 || wdata0 !== 32'h0 || hold0 !== 1'b1 || done0 !== 1'b0 ||
        error0 !== 1'b0 || in_ready0 !== 1'b1 || addr1 !== BASE1 || wdata1 !== 32'h0) begin
      bad++;
      $display("FAIL midreset_values we=%0b addr=%h/%h wdata=%h/%h hold=%0b done=%0b err=%0b rdy=%0b required 0 %h/%h 0/0 1 0 0 1",
               we0, addr0, addr1, wdata0, wdata1, hold0, done0, error0, in_ready0, BASE0, BASE1);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got0.delete(); got1.delete(); stim.delete();
    send_bytes('{8'hA5, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (got0.size() != 1 || got1.size() != 1 || done0 !== 1'b1) begin
      bad++;
      $display("FAIL midreset_reload writes=%0d/%0d done=%0b required 1 1", got0.size(), got1.size(), done0);
    end else begin
      total++;
      if (got0[0] !== 64'h0000_0000_DEAD_BEEF || got1[0] !== 64'h0000_0100_DEAD_BEEF) begin
        bad++;
        $display("FAIL midreset_write got=%h/%h required 00000000deadbeef/00000100deadbeef", got0[0], got1[0]);
      end
    end
  endtask

  task automatic test_random_frames();
    logic [7:0] fr[$];
    logic [7:0] b, chk;
    int len;
    for (int k = 0; k < 6; k++) begin
      apply_reset();
      fr.delete();
      repeat ($urandom_range(2)) fr.push_back(8'($urandom_range(8'hA4)));
      // optional rejected frame ahead of the good one
      for (int f = (k % 2 == 0) ? 0 : 1; f < 2; f++) begin
        len = $urandom_range(6, 1);
        fr.push_back(8'hA5);
        fr.push_back(8'(len));
        chk = 8'h00;
        for (int i = 0; i < 4 * len; i++) begin
          b = (i == 1 && k > 2) ? 8'hA5 : 8'($urandom);
          chk ^= b;
          fr.push_back(b);
        end
        fr.push_back((f == 0) ? (chk ^ 8'($urandom_range(255, 1))) : chk);
      end
      send_bytes(fr, 1'b1);
      repeat (3) @(negedge clk);
      model_run();
      total++;
      if (got0.size() != exp_data.size() || got1.size() != exp_data.size()) begin
        bad++;
        $display("FAIL rand%0d_count got=%0d/%0d required=%0d", k, got0.size(), got1.size(), exp_data.size());
      end else begin
        foreach (exp_data[i]) begin
          total++;
          if (got0[i] !== exp_wr(BASE0, i) || got1[i] !== exp_wr(BASE1, i)) begin
            bad++;
            $display("FAIL rand%0d_write%0d got=%h/%h required=%h/%h", k, i, got0[i], got1[i],
                     exp_wr(BASE0, i), exp_wr(BASE1, i));
          end
        end
      end
      total++;
      if (done0 !== exp_done || error0 !== exp_error || hold0 !== !exp_done || done1 !== exp_done) begin
        bad++;
        $display("FAIL rand%0d_status done=%0b err=%0b hold=%0b required %0b %0b %0b",
                 k, done0, error0, hold0, exp_done, exp_error, !exp_done);
      end
    end
  endtask

  task automatic test_base_and_done();
    logic [7:0] fr[$];
    logic [7:0] b, chk;
    apply_reset();
    fr = '{8'hA5, 8'h03};
    chk = 8'h00;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom);
      chk ^= b;
      fr.push_back(b);
    end
    fr.push_back(chk);
    send_bytes(fr, 1'b1);
    repeat (3) @(negedge clk);
    total++;
    if (got1.size() != 3 || done1 !== 1'b1) begin
      bad++;
      $display("FAIL base_count writes=%0d done=%0b required 3 1", got1.size(), done1);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got1[i][63:32] !== 32'h100 + 32'(4 * i)) begin
          bad++;
          $display("FAIL base_addr%0d got=%h required=%h", i, got1[i][63:32], 32'h100 + 32'(4 * i));
        end
      end
    end
    // bytes offered after completion are never taken
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = (i == 0) ? 8'hA5 : 8'($urandom);
      #1;
      total++;
      if (in_ready0 !== 1'b0 || in_ready1 !== 1'b0) begin
        bad++;
        $display("FAIL done_ready cycle=%0d in_ready=%0b/%0b required 0", i, in_ready0, in_ready1);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (got0.size() != 3 || got1.size() != 3 || done0 !== 1'b1 || hold0 !== 1'b0 || error0 !== 1'b0) begin
      bad++;
      $display("FAIL done_sticky writes=%0d/%0d done=%0b hold=%0b err=%0b required 3/3 1 0 0",
               got0.size(), got1.size(), done0, hold0, error0);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_bad_retry();
    test_len_limits();
    test_reset_midframe();
    test_random_frames();
    test_base_and_done();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time writer for the core's instruction memory. It accepts a framed byte stream on a valid/ready handshake and assembles the payload into 32-bit big-endian instruction words. It writes each word into instruction memory through a dedicated write port and holds the pipelined core stalled until a frame has loaded and its checksum matches. It sits beside the processor top level: on the write side of the instruction memory that the fetch stage reads.

## Interface
Parameters:
- IMEM_DEPTH, 64, instruction-memory capacity in 32-bit words; maximum accepted frame length.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte-stream source has in_data valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte this cycle.
- imem_we  out  1  instruction-memory write strobe, one cycle per word.
- imem_addr  out  32  byte address of the write, word-aligned.
- imem_wdata  out  32  instruction word, first received byte in [31:24].
- core_hold  out  1  high keeps the core stalled; low releases it.
- done  out  1  frame loaded and verified; sticky.
- error  out  1  frame rejected; clears on next SYNC_BYTE.

## Operation
Frame format is SYNC_BYTE, then LEN, then 4×LEN payload bytes, then CHK.
- LEN is the word count, valid range 1..IMEM_DEPTH.
- CHK is the XOR of all payload bytes.
- A byte is consumed on a rising edge when in_valid && in_ready.

States, with reset state IDLE:
- **IDLE:** discard every byte except SYNC_BYTE, which moves to LEN.
- **LEN:** latch LEN.
  - LEN==0 or LEN>IMEM_DEPTH → ERROR.
  - Otherwise clear the word index, byte counter and checksum accumulator, then go to DATA.
- **DATA:** shift each byte into a 32-bit packer and XOR it into the accumulator.
  - After the 4th byte → WRITE.
- **WRITE:** one cycle.
  - imem_we=1, imem_addr=BASE_ADDR+4×index, imem_wdata=packed word.
  - Then increment index; if index==LEN → CHECK, else → DATA.
- **CHECK:** compare the next byte to the accumulator.
  - Equal → DONE.
  - Not equal → ERROR.
- **DONE:** done=1, core_hold=0. Terminal until reset; all input is ignored.
- **ERROR:** error=1, core_hold=1.
  - Bytes are discarded.
  - SYNC_BYTE clears error and moves to LEN, restarting at BASE_ADDR.
  - Words written by the failed frame stay in memory and get overwritten by the retry.

in_ready is 1 in IDLE, LEN, DATA, CHECK and ERROR; it is 0 in WRITE and DONE.

## Timing
- All outputs are registered except in_ready, which is decoded from state.
- Reset values: imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, core_hold=1, done=0, error=0. State is IDLE, so in_ready reads 1; no byte is consumed while reset is asserted.
- imem_we rises on the edge after the 4th byte of a word is accepted and lasts exactly one cycle. imem_addr and imem_wdata are stable in that cycle.
- Throughput is 5 cycles per word with in_valid held high. Under gaps, the source holds in_data until the byte is accepted.
- done and core_hold change on the edge that accepts a matching CHK.
- Reset asserted mid-frame: the partial word and accumulator are discarded, outputs return to reset values at once (asynchronously), and the next frame starts at BASE_ADDR.
- The word index is sized clog2(IMEM_DEPTH+1) bits and cannot wrap, because LEN is bounded.
- A SYNC_BYTE value appearing inside LEN, DATA or CHECK is treated as data, not a restart.

## Structure
- Package boot_loader_pkg holds:
  - the state enum (IDLE, LEN, DATA, WRITE, CHECK, DONE, ERROR);
  - the word width (32) and byte width (8) constants.
- Sub-module byte_packer: a 4-byte shift register with a 2-bit count and a word_full flag. It has clear and shift inputs, and the FSM owns both.
- The top of the block holds the FSM, word index, LEN register and checksum accumulator.

## Test plan
- **Single word.** Send A5 01 DE AD BE EF 22. Expect one imem_we at addr 0 with wdata DEADBEEF, then done=1 and core_hold=0.
- **Two words, back-to-back.** Send A5 02 00 00 00 01 00 00 00 02 03 with in_valid held high. Expect:
  - writes of 00000001 at addr 0 and 00000002 at addr 4;
  - in_ready=0 for one cycle after each 4th byte, with no bytes lost.
- **Bad checksum, then retry.** Send A5 01 11 22 33 44 00. Expect error=1, core_hold=1, done=0. Then resend the frame with CHK 44: error clears on the A5, and done=1 follows.
- **Noise and length limits.**
  - Send 00 FF 3C, then a valid frame: the leading bytes are ignored and the frame loads normally.
  - Send A5 00, and separately A5 41 with IMEM_DEPTH=64: each sets error=1 after the LEN byte, with no imem_we.
- **Reset mid-frame.** Send A5 01 DE AD, then pulse reset low. Expect all outputs at reset values. Then send the single-word frame: the write lands at BASE_ADDR with DEADBEEF.
- **Nonzero base and DONE behaviour.** Set BASE_ADDR=32'h100 and load three words. Expect addresses 100, 104, 108. Then send more bytes in DONE: in_ready=0 and no further writes.
